// File: rtl/rhythm_judge_core.sv
// Rhythm-game judge: fetches goal notes, grades per-lane hits against timing windows, keeps score/combo totals.
// Optional build macro RHYTHM_JUDGE_AUTOPLAY_EN adds an autoplay input that self-hits every note dead on time.
module rhythm_judge_core #(
   parameter int LANES       = 8,
   parameter int CLOCK_BITS  = 20,
   parameter int SCORE_BITS  = 21,
   parameter int CNT_BITS    = 10,
   parameter int PERFECT_WIN = 4,
   parameter int GOOD_WIN    = 12,
   parameter int PERFECT_PTS = 300,
   parameter int GOOD_PTS    = 100,
   parameter int COMBO_SHIFT = 2,
   parameter int LANE_BITS   = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CLOCK_BITS-1:0] system_clock,
   input  logic [LANES-1:0]      hit,
`ifdef RHYTHM_JUDGE_AUTOPLAY_EN
   input  logic                  autoplay,
`endif
   input  logic                  note_valid,
   output logic                  note_ready,
   input  logic [LANE_BITS-1:0]  note_lane,
   input  logic [CLOCK_BITS-1:0] note_time,
   input  logic                  note_last,
   output logic                  judge_valid,
   output logic [1:0]            judge_grade,
   output logic [LANES-1:0]      lane_led,
   output logic [SCORE_BITS-1:0] score,
   output logic [CNT_BITS-1:0]   combo,
   output logic [CNT_BITS-1:0]   max_combo,
   output logic [CNT_BITS-1:0]   perfect_cnt,
   output logic [CNT_BITS-1:0]   good_cnt,
   output logic [CNT_BITS-1:0]   miss_cnt,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            state_dbg
);

   // Note handshake: a goal note transfers on a cycle where note_valid && note_ready;
   // note_ready is high only in FETCH, so exactly one note is taken per visit to FETCH.

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_JUDGE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [1:0] G_MISS    = 2'd0;
   localparam logic [1:0] G_GOOD    = 2'd1;
   localparam logic [1:0] G_PERFECT = 2'd2;

   localparam int SUMW = SCORE_BITS + CNT_BITS + 34;

   localparam logic signed [CLOCK_BITS-1:0] PERF_S = CLOCK_BITS'(PERFECT_WIN);
   localparam logic signed [CLOCK_BITS-1:0] GOOD_S = CLOCK_BITS'(GOOD_WIN);

   logic [2:0]            state_q, state_d;
   logic [LANE_BITS-1:0]  lane_q, lane_d;
   logic [CLOCK_BITS-1:0] time_q, time_d;
   logic                  last_q, last_d;
   logic [1:0]            grade_q, grade_d;
   logic                  judge_valid_q, judge_valid_d;
   logic [1:0]            judge_grade_q, judge_grade_d;
   logic [SCORE_BITS-1:0] score_q, score_d;
   logic [CNT_BITS-1:0]   combo_q, combo_d;
   logic [CNT_BITS-1:0]   max_combo_q, max_combo_d;
   logic [CNT_BITS-1:0]   perfect_q, perfect_d;
   logic [CNT_BITS-1:0]   good_q, good_d;
   logic [CNT_BITS-1:0]   miss_q, miss_d;

   logic signed [CLOCK_BITS-1:0] delta;
   logic [LANES-1:0]             lane_onehot;
   logic                         lane_hit;
   logic                         judged_hit;
   logic                         in_perfect;
   logic                         in_good;
   logic                         timed_out;
   logic [SUMW-1:0]              pts;
   logic [SUMW-1:0]              sum;
   logic [CNT_BITS-1:0]          combo_inc;

   function automatic logic [CNT_BITS-1:0] inc_sat(input logic [CNT_BITS-1:0] v);
      return (v == {CNT_BITS{1'b1}}) ? v : v + CNT_BITS'(1);
   endfunction

   // Modular subtraction read as two's complement keeps the windows correct across counter wrap.
   always_comb begin
      delta       = system_clock - time_q;
      lane_onehot = LANES'(1) << lane_q;
      lane_hit    = |(hit & lane_onehot);
`ifdef RHYTHM_JUDGE_AUTOPLAY_EN
      judged_hit  = autoplay ? (delta == '0) : lane_hit;
`else
      judged_hit  = lane_hit;
`endif
      in_perfect  = (delta >= -PERF_S) && (delta <= PERF_S);
      in_good     = (delta >= -GOOD_S) && (delta <= GOOD_S);
      timed_out   = (delta > GOOD_S);
   end

   always_comb begin
      pts       = (grade_q == G_PERFECT) ? SUMW'(PERFECT_PTS) : SUMW'(GOOD_PTS);
      sum       = SUMW'(score_q) + pts + SUMW'(combo_q >> COMBO_SHIFT);
      combo_inc = inc_sat(combo_q);
   end

   always_comb begin
      state_d       = state_q;
      lane_d        = lane_q;
      time_d        = time_q;
      last_d        = last_q;
      grade_d       = grade_q;
      judge_valid_d = 1'b0;
      judge_grade_d = judge_grade_q;
      score_d       = score_q;
      combo_d       = combo_q;
      max_combo_d   = max_combo_q;
      perfect_d     = perfect_q;
      good_d        = good_q;
      miss_d        = miss_q;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d     = S_FETCH;
                  score_d     = '0;
                  combo_d     = '0;
                  max_combo_d = '0;
                  perfect_d   = '0;
                  good_d      = '0;
                  miss_d      = '0;
               end
            end
            S_FETCH: begin
               if (note_valid) begin
                  lane_d  = note_lane;
                  time_d  = note_time;
                  last_d  = note_last;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               // An in-window hit wins over a timeout landing on the same cycle.
               if (judged_hit && in_good) begin
                  grade_d = in_perfect ? G_PERFECT : G_GOOD;
                  state_d = S_JUDGE;
               end else if (timed_out) begin
                  grade_d = G_MISS;
                  state_d = S_JUDGE;
               end
            end
            S_JUDGE: begin
               judge_valid_d = 1'b1;
               judge_grade_d = grade_q;
               state_d       = last_q ? S_DONE : S_FETCH;
               if (grade_q == G_MISS) begin
                  combo_d = '0;
                  miss_d  = inc_sat(miss_q);
               end else begin
                  score_d     = (sum[SUMW-1:SCORE_BITS] != '0) ? {SCORE_BITS{1'b1}}
                                                              : sum[SCORE_BITS-1:0];
                  combo_d     = combo_inc;
                  max_combo_d = (combo_inc > max_combo_q) ? combo_inc : max_combo_q;
                  if (grade_q == G_PERFECT) perfect_d = inc_sat(perfect_q);
                  else                      good_d    = inc_sat(good_q);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         lane_q        <= '0;
         time_q        <= '0;
         last_q        <= 1'b0;
         grade_q       <= G_MISS;
         judge_valid_q <= 1'b0;
         judge_grade_q <= G_MISS;
         score_q       <= '0;
         combo_q       <= '0;
         max_combo_q   <= '0;
         perfect_q     <= '0;
         good_q        <= '0;
         miss_q        <= '0;
      end else begin
         state_q       <= state_d;
         lane_q        <= lane_d;
         time_q        <= time_d;
         last_q        <= last_d;
         grade_q       <= grade_d;
         judge_valid_q <= judge_valid_d;
         judge_grade_q <= judge_grade_d;
         score_q       <= score_d;
         combo_q       <= combo_d;
         max_combo_q   <= max_combo_d;
         perfect_q     <= perfect_d;
         good_q        <= good_d;
         miss_q        <= miss_d;
      end
   end

   assign note_ready  = (state_q == S_FETCH);
   assign lane_led    = (state_q == S_WAIT) ? lane_onehot : '0;
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done        = (state_q == S_DONE);
   assign judge_valid = judge_valid_q;
   assign judge_grade = judge_grade_q;
   assign score       = score_q;
   assign combo       = combo_q;
   assign max_combo   = max_combo_q;
   assign perfect_cnt = perfect_q;
   assign good_cnt    = good_q;
   assign miss_cnt    = miss_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_rhythm_judge_core.sv
// Directed bench for rhythm_judge_core: hand-computed grades, scores and combos across a short song.
module tb_rhythm_judge_core;

   localparam int LANES = 8;
   localparam int CB    = 20;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [CB-1:0]   system_clock = '0;
   logic [LANES-1:0] hit = '0;
   logic            note_valid = 1'b0;
   logic            note_ready;
   logic [2:0]      note_lane = '0;
   logic [CB-1:0]   note_time = '0;
   logic            note_last = 1'b0;
   logic            judge_valid;
   logic [1:0]      judge_grade;
   logic [LANES-1:0] lane_led;
   logic [20:0]     score;
   logic [9:0]      combo, max_combo, perfect_cnt, good_cnt, miss_cnt;
   logic            busy, done;
   logic [2:0]      state_dbg;

   int n_checks = 0;
   int n_bad    = 0;

   rhythm_judge_core dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .system_clock(system_clock), .hit(hit),
      .note_valid(note_valid), .note_ready(note_ready), .note_lane(note_lane),
      .note_time(note_time), .note_last(note_last),
      .judge_valid(judge_valid), .judge_grade(judge_grade), .lane_led(lane_led),
      .score(score), .combo(combo), .max_combo(max_combo),
      .perfect_cnt(perfect_cnt), .good_cnt(good_cnt), .miss_cnt(miss_cnt),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Inputs change after a falling edge; outputs are observed at falling edges.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic send_note(input logic [2:0] lane, input logic [CB-1:0] t, input logic last);
      int n = 0;
      note_valid = 1'b1;
      note_lane  = lane;
      note_time  = t;
      note_last  = last;
      while (!note_ready && n < 20) begin
         step();
         n++;
      end
      check("note_ready_fetch", note_ready, 1);
      step();
      note_valid = 1'b0;
   endtask

   task automatic hit_note(input logic [2:0] lane, input logic [CB-1:0] t, input int d,
                           input logic last, input logic [1:0] exp_grade);
      system_clock = t - CB'(100);
      send_note(lane, t, last);
      system_clock = CB'(int'(t) + d);
      hit = LANES'(1) << lane;
      step();
      hit = '0;
      check("jv_latency1", judge_valid, 0);
      step();
      check("jv_pulse", judge_valid, 1);
      check("grade", judge_grade, exp_grade);
   endtask

   int perf_d[7] = '{0, -4, 4, 1, -1, 3, -3};

   initial begin
      // reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_score", score, 0);
      check("rst_combo", combo, 0);
      check("rst_max", max_combo, 0);
      check("rst_cnts", {perfect_cnt, good_cnt, miss_cnt}, 0);
      check("rst_ready", note_ready, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_jv", judge_valid, 0);
      check("rst_grade", judge_grade, 0);
      check("rst_led", lane_led, 0);
      check("rst_state", state_dbg, 0);

      hit = 8'hff;
      step();
      hit = '0;
      check("idle_hit_ignored", judge_valid, 0);

      start = 1'b1;
      step();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_ready", note_ready, 1);

      // first note: lane 2, time 1000, hit at 1002
      system_clock = 20'd900;
      send_note(3'd2, 20'd1000, 1'b0);
      check("wait_led", lane_led, 8'b0000_0100);
      check("wait_ready", note_ready, 0);
      system_clock = 20'd1002;
      hit = 8'b0000_0100;
      step();
      hit = '0;
      check("first_lat1", judge_valid, 0);
      step();
      check("first_jv", judge_valid, 1);
      check("first_grade", judge_grade, 2);
      check("first_score", score, 300);
      check("first_combo", combo, 1);
      check("first_perfect", perfect_cnt, 1);
      step();
      check("jv_one_cycle", judge_valid, 0);
      check("back_fetch", state_dbg, 1);

      // build combo to 8, boundary deltas +-4 stay PERFECT
      for (int i = 0; i < 7; i++)
         hit_note(3'(i), CB'(1100 + 100 * i), perf_d[i], 1'b0, 2'd2);
      check("combo8_score", score, 2404);
      check("combo8", combo, 8);

      // GOOD at +10 with combo 8: +100 +2
      hit_note(3'd5, 20'd2000, 10, 1'b0, 2'd1);
      check("good_score", score, 2506);
      check("good_combo", combo, 9);
      check("good_cnt", good_cnt, 1);
      check("good_max", max_combo, 9);
      check("good_perf", perfect_cnt, 8);

      // MISS path: early hit and other-lane hit ignored, timeout at 513
      system_clock = 20'd400;
      send_note(3'd3, 20'd500, 1'b0);
      system_clock = 20'd487;
      hit = 8'b0000_1000;
      step();
      hit = '0;
      check("early_ignored", lane_led, 8'b0000_1000);
      system_clock = 20'd500;
      hit = 8'b0010_0000;
      step();
      hit = '0;
      check("other_lane_ignored", lane_led, 8'b0000_1000);
      system_clock = 20'd512;
      step();
      check("no_timeout_512", state_dbg, 2);
      system_clock = 20'd513;
      step();
      check("miss_lat1", judge_valid, 0);
      step();
      check("miss_jv", judge_valid, 1);
      check("miss_grade", judge_grade, 0);
      check("miss_combo", combo, 0);
      check("miss_cnt", miss_cnt, 1);
      check("miss_score", score, 2506);
      check("miss_max", max_combo, 9);

      // wrap: note at 2^20-3, hit at system_clock 2
      hit_note(3'd1, 20'hffffd, 5, 1'b0, 2'd1);
      check("wrap_score", score, 2606);
      check("wrap_combo", combo, 1);
      check("wrap_good", good_cnt, 2);

      // GOOD window edges and out-of-window hit on the timeout cycle
      hit_note(3'd0, 20'd3000, -12, 1'b0, 2'd1);
      check("edge_m12_score", score, 2706);
      hit_note(3'd7, 20'd3500, 12, 1'b0, 2'd1);
      check("edge_p12_score", score, 2806);
      check("edge_combo", combo, 3);
      hit_note(3'd4, 20'd4000, 13, 1'b0, 2'd0);
      check("late_hit_combo", combo, 0);
      check("late_hit_miss", miss_cnt, 2);
      check("late_hit_score", score, 2806);

      // last note -> DONE
      hit_note(3'd6, 20'd5000, 0, 1'b1, 2'd2);
      check("last_score", score, 3106);
      check("last_perf", perfect_cnt, 9);
      check("last_done", done, 1);
      check("last_ready", note_ready, 0);
      check("last_busy", busy, 0);
      hit = 8'hff;
      step();
      hit = '0;
      step();
      check("done_hit_jv", judge_valid, 0);
      check("done_hit_score", score, 3106);

      // restart clears totals, judge_grade held
      start = 1'b1;
      step();
      start = 1'b0;
      check("rs_score", score, 0);
      check("rs_combo", combo, 0);
      check("rs_max", max_combo, 0);
      check("rs_cnts", {perfect_cnt, good_cnt, miss_cnt}, 0);
      check("rs_done", done, 0);
      check("rs_ready", note_ready, 1);
      check("rs_grade_held", judge_grade, 2);
      hit_note(3'd0, 20'd7000, -2, 1'b0, 2'd2);
      check("rs_score1", score, 300);

      // abort in WAIT beats an in-window hit
      system_clock = 20'd7900;
      send_note(3'd1, 20'd8000, 1'b0);
      check("ab_led", lane_led, 8'b0000_0010);
      abort = 1'b1;
      system_clock = 20'd8000;
      hit = 8'b0000_0010;
      step();
      abort = 1'b0;
      hit = '0;
      check("ab_state", state_dbg, 0);
      check("ab_busy", busy, 0);
      check("ab_jv0", judge_valid, 0);
      step();
      check("ab_jv1", judge_valid, 0);
      check("ab_score", score, 300);
      check("ab_combo", combo, 1);
      check("ab_perf", perfect_cnt, 1);
      check("ab_grade", judge_grade, 2);
      check("ab_led0", lane_led, 0);
      check("ab_ready", note_ready, 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
